// File: rtl/ts_ci_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ts_ci_bridge
// Purpose  : Transport-stream bridge between the internal TS datapath and the
//            Common Interface CAM MPEG-TS bus.
//            IN  : bytes from the TS proxy are queued in a FWFT FIFO and
//                  serialised onto CI_MDI under a locally divided CI_MCLKI,
//                  with CI_MISTRT marking 0x47 packet starts.
//            OUT : CI_MCLKO/CI_MDO/CI_MOSTRT/CI_MOVAL are synchronised into
//                  clk, and accepted packets are returned to the proxy as
//                  single-cycle write strobes.
// Ports    : clk, reset                      - system clock, sync active-high reset
//            ts_ci_in_d, ts_ci_wrreq         - IN byte + write strobe
//            ts_ci_almost_full               - IN FIFO count >= AFULL_LEVEL
//            CI_MDI/CI_MCLKI/CI_MISTRT/CI_MIVAL - TS bus to the CAM
//            CI_MDO/CI_MCLKO/CI_MOSTRT/CI_MOVAL - TS bus from the CAM (async)
//            ts_ci_out_d, ts_ci_out_wrreq    - OUT byte + one-cycle strobe
//            ts_ci_out_almost_full           - downstream back-pressure
// Revision : 1.0 - initial release
// ============================================================================
module ts_ci_bridge #(
    parameter int CLK_DIV     = 8,
    parameter int FIFO_DEPTH  = 32,
    parameter int AFULL_LEVEL = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ts_ci_in_d,
    input  logic       ts_ci_wrreq,
    output logic       ts_ci_almost_full,
    output logic [7:0] CI_MDI,
    output logic       CI_MCLKI,
    output logic       CI_MISTRT,
    output logic       CI_MIVAL,
    input  logic [7:0] CI_MDO,
    input  logic       CI_MCLKO,
    input  logic       CI_MOSTRT,
    input  logic       CI_MOVAL,
    output logic [7:0] ts_ci_out_d,
    output logic       ts_ci_out_wrreq,
    input  logic       ts_ci_out_almost_full
);

    localparam int c_aw    = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_aw + 1;
    localparam int c_div_w = $clog2(CLK_DIV);

    localparam logic [c_cnt_w-1:0] c_fifo_full  = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_afull      = c_cnt_w'(AFULL_LEVEL);
    localparam logic [c_div_w-1:0] c_div_half   = c_div_w'(CLK_DIV / 2 - 1);
    localparam logic [c_div_w-1:0] c_div_last   = c_div_w'(CLK_DIV - 1);
    localparam logic [7:0]         c_sync_byte  = 8'h47;
    localparam logic [7:0]         c_pkt_last   = 8'd187;

    // OUT packet gate states
    localparam logic [0:0] S_DROP = 1'b0;
    localparam logic [0:0] S_PASS = 1'b1;

    // ------------------------------------------------------------------------
    // IN FIFO (first-word-fall-through)
    // ------------------------------------------------------------------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_div_w-1:0] r_div_cnt;
    logic [7:0]         r_pkt_cnt;

    logic               w_slot;
    logic               w_push;
    logic               w_pop;
    logic [7:0]         w_head;
    logic [c_cnt_w-1:0] w_cnt_next;

    assign w_slot     = (r_div_cnt == c_div_last);
    assign w_push     = ts_ci_wrreq && (r_count != c_fifo_full);
    assign w_pop      = w_slot && (r_count != '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_cnt_next = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

    // Storage needs no reset: the empty count guards every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ts_ci_in_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr          <= '0;
            r_rd_ptr          <= '0;
            r_count           <= '0;
            ts_ci_almost_full <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count           <= w_cnt_next;
            ts_ci_almost_full <= (w_cnt_next >= c_afull);
        end
    end

    // ------------------------------------------------------------------------
    // CI_MCLKI divider, byte slot and packet framing.
    // The slot updates together with the CI_MCLKI fall, so CI_MDI is stable
    // for half a period either side of the rising edge the CAM samples on.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_pkt_cnt <= '0;
            CI_MCLKI  <= 1'b0;
            CI_MDI    <= '0;
            CI_MIVAL  <= 1'b0;
            CI_MISTRT <= 1'b0;
        end else begin
            if (w_slot) begin
                r_div_cnt <= '0;
                CI_MCLKI  <= 1'b0;
                if (r_count != '0) begin
                    CI_MDI   <= w_head;
                    CI_MIVAL <= 1'b1;
                    if (r_pkt_cnt == '0) begin
                        // Hunting: only a sync byte opens a packet; other
                        // bytes still go out, unmarked.
                        if (w_head == c_sync_byte) begin
                            CI_MISTRT <= 1'b1;
                            r_pkt_cnt <= 8'd1;
                        end else begin
                            CI_MISTRT <= 1'b0;
                        end
                    end else begin
                        CI_MISTRT <= 1'b0;
                        r_pkt_cnt <= (r_pkt_cnt == c_pkt_last) ? 8'd0 : r_pkt_cnt + 8'd1;
                    end
                end else begin
                    CI_MIVAL  <= 1'b0;
                    CI_MISTRT <= 1'b0;
                end
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
                if (r_div_cnt == c_div_half) begin
                    CI_MCLKI <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // OUT path: synchronisers, edge detect and packet gate
    // ------------------------------------------------------------------------
    logic       r_clko_s1, r_clko_s2, r_clko_s3;
    logic [7:0] r_mdo_s1,  r_mdo_s2;
    logic       r_strt_s1, r_strt_s2;
    logic       r_val_s1,  r_val_s2;
    logic [0:0] r_gate;

    logic       w_rise;
    logic       w_accept;

    assign w_rise = r_clko_s2 & ~r_clko_s3;

    // A start byte is judged by the gate decision it itself makes.
    always_comb begin
        w_accept = 1'b0;
        if (w_rise && r_val_s2) begin
            if (r_strt_s2) begin
                w_accept = ~ts_ci_out_almost_full;
            end else begin
                w_accept = (r_gate == S_PASS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clko_s1       <= 1'b0;
            r_clko_s2       <= 1'b0;
            r_clko_s3       <= 1'b0;
            r_mdo_s1        <= '0;
            r_mdo_s2        <= '0;
            r_strt_s1       <= 1'b0;
            r_strt_s2       <= 1'b0;
            r_val_s1        <= 1'b0;
            r_val_s2        <= 1'b0;
            r_gate          <= S_DROP;
            ts_ci_out_d     <= '0;
            ts_ci_out_wrreq <= 1'b0;
        end else begin
            r_clko_s1 <= CI_MCLKO;
            r_clko_s2 <= r_clko_s1;
            r_clko_s3 <= r_clko_s2;
            r_mdo_s1  <= CI_MDO;
            r_mdo_s2  <= r_mdo_s1;
            r_strt_s1 <= CI_MOSTRT;
            r_strt_s2 <= r_strt_s1;
            r_val_s1  <= CI_MOVAL;
            r_val_s2  <= r_val_s1;

            // Back-pressure is only consulted at packet start, so a packet
            // already passing always completes.
            if (w_rise && r_val_s2 && r_strt_s2) begin
                r_gate <= ts_ci_out_almost_full ? S_DROP : S_PASS;
            end

            ts_ci_out_wrreq <= w_accept;
            if (w_accept) begin
                ts_ci_out_d <= r_mdo_s2;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ts_ci_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ts_ci_bridge
// Purpose  : Directed self-checking bench for ts_ci_bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ts_ci_bridge;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ts_ci_in_d = '0;
    logic       ts_ci_wrreq = 1'b0;
    logic       ts_ci_almost_full;
    logic [7:0] CI_MDI;
    logic       CI_MCLKI;
    logic       CI_MISTRT;
    logic       CI_MIVAL;
    logic [7:0] CI_MDO = '0;
    logic       CI_MCLKO = 1'b0;
    logic       CI_MOSTRT = 1'b0;
    logic       CI_MOVAL = 1'b0;
    logic [7:0] ts_ci_out_d;
    logic       ts_ci_out_wrreq;
    logic       ts_ci_out_almost_full = 1'b0;

    int errors = 0;
    int checks = 0;

    ts_ci_bridge #(.CLK_DIV(8), .FIFO_DEPTH(32), .AFULL_LEVEL(24)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ts_ci_in_d            (ts_ci_in_d),
        .ts_ci_wrreq           (ts_ci_wrreq),
        .ts_ci_almost_full     (ts_ci_almost_full),
        .CI_MDI                (CI_MDI),
        .CI_MCLKI              (CI_MCLKI),
        .CI_MISTRT             (CI_MISTRT),
        .CI_MIVAL              (CI_MIVAL),
        .CI_MDO                (CI_MDO),
        .CI_MCLKO              (CI_MCLKO),
        .CI_MOSTRT             (CI_MOSTRT),
        .CI_MOVAL              (CI_MOVAL),
        .ts_ci_out_d           (ts_ci_out_d),
        .ts_ci_out_wrreq       (ts_ci_out_wrreq),
        .ts_ci_out_almost_full (ts_ci_out_almost_full)
    );

    always #5 clk = ~clk;

    // Captured IN bytes {CI_MISTRT, CI_MDI} at each CI_MCLKI fall with valid.
    logic [8:0] in_q[$];
    logic [7:0] out_q[$];
    logic       m_prev_mclki = 1'b0;
    logic       m_prev_wr = 1'b0;
    int         dbl_pulses = 0;

    always @(negedge clk) begin
        if (m_prev_mclki && !CI_MCLKI && CI_MIVAL) begin
            in_q.push_back({CI_MISTRT, CI_MDI});
        end
        m_prev_mclki = CI_MCLKI;
        if (ts_ci_out_wrreq) begin
            out_q.push_back(ts_ci_out_d);
        end
        if (ts_ci_out_wrreq && m_prev_wr) begin
            dbl_pulses++;
        end
        m_prev_wr = ts_ci_out_wrreq;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at a negedge where reset has just been released, so the next
    // posedge is the first post-reset edge.
    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        ts_ci_wrreq = 1'b0;
        CI_MCLKO = 1'b0;
        CI_MOVAL = 1'b0;
        CI_MOSTRT = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mdi",     CI_MDI, 0);
        check("rst_mclki",   CI_MCLKI, 0);
        check("rst_mistrt",  CI_MISTRT, 0);
        check("rst_mival",   CI_MIVAL, 0);
        check("rst_out_d",   ts_ci_out_d, 0);
        check("rst_out_wr",  ts_ci_out_wrreq, 0);
        check("rst_afull",   ts_ci_almost_full, 0);
        reset = 1'b0;
    endtask

    task automatic in_write(input logic [7:0] b);
        @(negedge clk);
        ts_ci_in_d = b;
        ts_ci_wrreq = 1'b1;
        @(negedge clk);
        ts_ci_wrreq = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // One CAM byte at clk/8: 4 cycles low, 4 high. Data changes with the fall.
    task automatic cam_byte(input logic [7:0] d, input logic st, input logic v, input logic lat);
        CI_MCLKO = 1'b0;
        CI_MDO = d;
        CI_MOSTRT = st;
        CI_MOVAL = v;
        repeat (4) @(negedge clk);
        CI_MCLKO = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (lat) check("out_latency", ts_ci_out_wrreq, (k == 2) ? 1 : 0);
        end
    endtask

    initial begin
        logic [7:0] eb;
        logic       es;

        // ---- Reset and idle divider ----
        reset_dut();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("idle_mclki", CI_MCLKI, (k / 4) % 2);
            check("idle_mival", CI_MIVAL, 0);
        end

        // ---- Full packet + repeated sync byte ----
        reset_dut();
        in_q.delete();
        in_write(8'h47);
        for (int i = 1; i <= 187; i++) in_write(8'(i));
        in_write(8'h47);
        repeat (24) @(negedge clk);
        check("pkt_count", in_q.size(), 189);
        for (int i = 0; i < 189 && i < in_q.size(); i++) begin
            eb = (i == 0 || i == 188) ? 8'h47 : 8'(i);
            es = (i == 0 || i == 188);
            check("pkt_byte", in_q[i], {es, eb});
        end

        // ---- Hunting for sync ----
        reset_dut();
        in_q.delete();
        in_write(8'h00);
        in_write(8'h11);
        in_write(8'h47);
        in_write(8'h05);
        repeat (24) @(negedge clk);
        check("hunt_count", in_q.size(), 4);
        if (in_q.size() == 4) begin
            check("hunt_b0", in_q[0], 9'h000);
            check("hunt_b1", in_q[1], 9'h011);
            check("hunt_b2", in_q[2], 9'h147);
            check("hunt_b3", in_q[3], 9'h005);
        end

        // ---- Burst of 40 from reset: byte i is sampled at post-reset edge i.
        // Pops occur every 8th edge, so count after edge k is k - k/8 until
        // full at edge 36; bytes 37..40 are dropped.
        reset_dut();
        in_q.delete();
        for (int i = 1; i <= 40; i++) begin
            ts_ci_in_d = 8'(i);
            ts_ci_wrreq = 1'b1;
            @(negedge clk);
            if (i == 26) check("afull_at_23", ts_ci_almost_full, 0);
            if (i == 27) check("afull_at_24", ts_ci_almost_full, 1);
            if (i == 40) check("afull_full",  ts_ci_almost_full, 1);
        end
        ts_ci_wrreq = 1'b0;
        repeat (320) @(negedge clk);
        check("burst_count", in_q.size(), 36);
        for (int i = 0; i < 36 && i < in_q.size(); i++) begin
            check("burst_byte", in_q[i], {1'b0, 8'(i + 1)});
        end

        // ---- OUT: bytes before MOSTRT dropped, then a full packet ----
        reset_dut();
        out_q.delete();
        cam_byte(8'hAA, 1'b0, 1'b1, 1'b0);
        cam_byte(8'hBB, 1'b0, 1'b1, 1'b0);
        cam_byte(8'hCC, 1'b0, 1'b1, 1'b0);
        check("pre_start_none", out_q.size(), 0);
        cam_byte(8'h47, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 187; i++) begin
            cam_byte(8'(i), 1'b0, 1'b1, (i == 1) ? 1'b1 : 1'b0);
            if (i == 100) cam_byte(8'hEE, 1'b0, 1'b0, 1'b0);
        end
        cam_byte(8'h00, 1'b0, 1'b0, 1'b0);
        check("out_count", out_q.size(), 188);
        for (int i = 0; i < 188 && i < out_q.size(); i++) begin
            check("out_byte", out_q[i], (i == 0) ? 8'h47 : 8'(i));
        end

        // ---- OUT: reset mid-packet discards the rest ----
        out_q.delete();
        cam_byte(8'h47, 1'b1, 1'b1, 1'b0);
        cam_byte(8'h10, 1'b0, 1'b1, 1'b0);
        cam_byte(8'h11, 1'b0, 1'b1, 1'b0);
        reset_dut();
        cam_byte(8'h20, 1'b0, 1'b1, 1'b0);
        cam_byte(8'h21, 1'b0, 1'b1, 1'b0);
        cam_byte(8'h00, 1'b0, 1'b0, 1'b0);
        check("mid_rst_count", out_q.size(), 3);
        if (out_q.size() == 3) begin
            check("mid_rst_b0", out_q[0], 8'h47);
            check("mid_rst_b2", out_q[2], 8'h11);
        end

        // ---- OUT: back-pressure at start drops the whole packet ----
        out_q.delete();
        ts_ci_out_almost_full = 1'b1;
        cam_byte(8'h47, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) cam_byte(8'(i), 1'b0, 1'b1, 1'b0);
        ts_ci_out_almost_full = 1'b0;
        for (int i = 10; i <= 20; i++) cam_byte(8'(i), 1'b0, 1'b1, 1'b0);
        check("af_drop_count", out_q.size(), 0);
        cam_byte(8'h47, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) cam_byte(8'h30 + 8'(i), 1'b0, 1'b1, 1'b0);
        cam_byte(8'h00, 1'b0, 1'b0, 1'b0);
        check("af_next_count", out_q.size(), 6);
        for (int i = 0; i < 6 && i < out_q.size(); i++) begin
            check("af_next_byte", out_q[i], (i == 0) ? 8'h47 : 8'h30 + 8'(i));
        end

        check("no_double_pulse", dbl_pulses, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
